// File: rtl/rcv_fifo_if.sv
// Bus-side signal bundle of the receive word buffer: the address/data-phase
// capture inputs, the consumer pop and flush, and the status/data returned.
interface rcv_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) ();

  logic                     rcv_enq_word;
  logic                     HREADY;
  logic [WIDTH-1:0]         HWDATA;
  logic                     fifo_clr;
  logic                     deq;
  logic [WIDTH-1:0]         rdata;
  logic                     rcv_fifo_full;
  logic                     rcv_fifo_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     fifo_err;

  // Driver of the request side (decode block plus consumer).
  modport master (
    output rcv_enq_word, HREADY, HWDATA, fifo_clr, deq,
    input  rdata, rcv_fifo_full, rcv_fifo_empty, count, fifo_err
  );

  // The buffer itself.
  modport slave (
    input  rcv_enq_word, HREADY, HWDATA, fifo_clr, deq,
    output rdata, rcv_fifo_full, rcv_fifo_empty, count, fifo_err
  );

endinterface

// File: rtl/rcv_fifo.sv
// Receive-side word buffer of the AHB slave. A two-state capture FSM tracks
// the outstanding data phase of each accepted address phase, the captured
// words go into a DEPTH-entry FIFO, and the head word is shown ahead to the
// cipher/key-expansion consumer.
module rcv_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic       HCLK,
  input  logic       HRESET,
  rcv_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             fifo_err;
  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_fire;   // data phase completes this cycle
  logic wr_ok;     // ... and there is room to keep the word
  logic rd_ok;     // pop of a stored word

  assign wr_fire = (state == PEND) && bus.HREADY;
  assign wr_ok   = wr_fire && (count != CW'(DEPTH));
  assign rd_ok   = bus.deq && (count != '0);

  // Capture FSM, pointers, occupancy and sticky error.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fifo_err <= 1'b0;
    end else if (bus.fifo_clr) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fifo_err <= 1'b0;
    end else begin
      // A phase only completes with HREADY high; otherwise hold (stretch).
      if (bus.HREADY) state <= bus.rcv_enq_word ? PEND : IDLE;
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((wr_fire && !wr_ok) || (bus.deq && !rd_ok)) fifo_err <= 1'b1;
    end
  end

  // Word storage write port.
  // NOTE: the array has no reset; its contents are only observable through
  // rptr/count, which are reset, so clearing it would buy nothing.
  always_ff @(posedge HCLK) begin
    if (wr_ok && !bus.fifo_clr) mem[wptr] <= bus.HWDATA;
  end

  // Status is a function of registered state only; the pending reservation
  // counts as an occupied slot for full but not for empty.
  assign bus.rcv_fifo_full  = (count + CW'(state == PEND)) == CW'(DEPTH);
  assign bus.rcv_fifo_empty = (count == '0);
  assign bus.count          = count;
  assign bus.fifo_err       = fifo_err;
  assign bus.rdata          = mem[rptr];

endmodule

// File: tb/tb_rcv_fifo.sv
// Directed bench for rcv_fifo: a table of per-cycle stimulus with the status
// expected at the start of that cycle, plus a hand-written async-reset case.
module tb_rcv_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic HCLK = 1'b0;
  logic HRESET;

  rcv_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rcv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        enq;
    logic        hr;
    logic [31:0] wd;
    logic        clr;
    logic        deq;
    logic        e_empty;
    logic        e_full;   // x = not checked
    logic [3:0]  e_count;
    logic        e_err;
    bit          chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic enq, input logic hr, input logic [31:0] wd,
                              input logic clr, input logic deq, input logic e_empty,
                              input logic e_full, input logic [3:0] e_count,
                              input logic e_err, input bit chk_rd, input logic [31:0] e_rd);
    vec_t v;
    v.enq = enq; v.hr = hr; v.wd = wd; v.clr = clr; v.deq = deq;
    v.e_empty = e_empty; v.e_full = e_full; v.e_count = e_count;
    v.e_err = e_err; v.chk_rd = chk_rd; v.e_rd = e_rd;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic enq, input logic hr, input logic [31:0] wd,
                       input logic clr, input logic deq);
    bus.rcv_enq_word = enq;
    bus.HREADY       = hr;
    bus.HWDATA       = wd;
    bus.fifo_clr     = clr;
    bus.deq          = deq;
  endtask

  initial begin
    // ---- build the vector table ----
    // 8-beat burst, then drain.
    add(1, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 1; k <= 7; k++)
      add(1, 1, 32'h1000_0000 + 32'(k - 1), 0, 0, k == 1, 0, 4'(k - 1), 0, k > 1, 32'h1000_0000);
    add(0, 1, 32'h1000_0007, 0, 0, 0, 1, 7, 0, 1, 32'h1000_0000);
    for (int j = 0; j < 8; j++)
      add(0, 1, 32'h0, 0, 1, 0, j == 0, 4'(8 - j), 0, 1, 32'h1000_0000 + 32'(j));
    add(0, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // Stretched data phase: three HREADY=0 cycles, data changes as it rises.
    add(1, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int j = 0; j < 3; j++)
      add(0, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    add(0, 1, 32'hCAFE_F00D, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    add(0, 1, 32'h0, 0, 1, 0, 0, 1, 0, 1, 32'hCAFE_F00D);
    add(0, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // Fill to 4, then 20 cycles of concurrent write and pop, then drain.
    add(1, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++)
      add(1, 1, 32'hB000_0000 + 32'(k), 0, 0, k == 0, 0, 4'(k), 0, k > 0, 32'hB000_0000);
    for (int i = 0; i < 20; i++)
      add(1, 1, 32'hA5A5_A5A5, 0, 1, 0, 0, 4, 0, 1,
          (i < 4) ? 32'hB000_0000 + 32'(i) : 32'hA5A5_A5A5);
    add(0, 1, 32'hA5A5_A5A5, 0, 1, 0, 0, 4, 0, 1, 32'hA5A5_A5A5);
    for (int j = 0; j < 4; j++)
      add(0, 1, 32'h0, 0, 1, 0, 0, 4'(4 - j), 0, 1, 32'hA5A5_A5A5);
    add(0, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // Overflow, flush, underflow, flush.
    add(1, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 1; k <= 7; k++)
      add(1, 1, 32'hC000_0000 + 32'(k - 1), 0, 0, k == 1, 0, 4'(k - 1), 0, k > 1, 32'hC000_0000);
    add(0, 1, 32'hC000_0007, 0, 0, 0, 1, 7, 0, 1, 32'hC000_0000);
    add(1, 1, 32'h0, 0, 0, 0, 1, 8, 0, 1, 32'hC000_0000);
    add(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 1'bx, 8, 0, 1, 32'hC000_0000);
    add(0, 1, 32'h0, 1, 0, 0, 1, 8, 1, 1, 32'hC000_0000);
    add(0, 1, 32'h0, 0, 1, 1, 0, 0, 0, 0, 32'h0);
    add(0, 1, 32'h0, 1, 0, 1, 0, 0, 1, 0, 32'h0);
    add(0, 1, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0);

    // ---- reset ----
    drive(0, 1, 32'h0, 0, 0);
    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    // ---- apply the table ----
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge HCLK);
      check($sformatf("v%0d empty", i), 32'(bus.rcv_fifo_empty), 32'(vq[i].e_empty));
      if (vq[i].e_full !== 1'bx)
        check($sformatf("v%0d full", i), 32'(bus.rcv_fifo_full), 32'(vq[i].e_full));
      check($sformatf("v%0d count", i), 32'(bus.count), 32'(vq[i].e_count));
      check($sformatf("v%0d err", i), 32'(bus.fifo_err), 32'(vq[i].e_err));
      if (vq[i].chk_rd)
        check($sformatf("v%0d rdata", i), bus.rdata, vq[i].e_rd);
      drive(vq[i].enq, vq[i].hr, vq[i].wd, vq[i].clr, vq[i].deq);
    end

    // ---- async reset while a data phase is pending, count=3 ----
    @(negedge HCLK); drive(1, 1, 32'h0, 0, 0);
    @(negedge HCLK); drive(1, 1, 32'hD000_0000, 0, 0);
    @(negedge HCLK); drive(1, 1, 32'hD000_0001, 0, 0);
    @(negedge HCLK); drive(1, 1, 32'hD000_0002, 0, 0);
    @(negedge HCLK);
    check("rst pre count", 32'(bus.count), 32'd3);
    drive(0, 0, 32'hEEEE_EEEE, 0, 0);
    #2 HRESET = 1'b1;
    #1;
    check("rst empty", 32'(bus.rcv_fifo_empty), 32'd1);
    check("rst count", 32'(bus.count), 32'd0);
    check("rst full", 32'(bus.rcv_fifo_full), 32'd0);
    check("rst err", 32'(bus.fifo_err), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(1, 1, 32'h0, 0, 0);
    @(negedge HCLK); drive(0, 1, 32'h0000_0011, 0, 0);
    @(negedge HCLK);
    check("post-rst count", 32'(bus.count), 32'd1);
    check("post-rst empty", 32'(bus.rcv_fifo_empty), 32'd0);
    check("post-rst rdata", bus.rdata, 32'h0000_0011);
    drive(0, 1, 32'h0, 0, 1);
    @(negedge HCLK);
    check("post-rst drain", 32'(bus.rcv_fifo_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rcv_fifo.md
# rcv_fifo

Receive-side word buffer of the AHB slave. It captures write data for accepted input and key bursts, which the AHB register/decode block flags during the address phase with `rcv_enq_word`. It buffers the words in a DEPTH-entry FIFO and presents them show-ahead to the downstream cipher/key-expansion consumer. It also returns the `rcv_fifo_full` and `rcv_fifo_empty` flags that the decode block uses to insert wait states.

## Interface
- WIDTH, 32, data word width
- DEPTH, 8, number of entries; must be a power of 2, at least 2
- HCLK  in  1  system clock; all state updates on its rising edge
- HRESET  in  1  asynchronous, active-high reset
- rcv_enq_word  in  1  address-phase request to store one word
- HREADY  in  1  bus ready; a transfer phase completes only in a cycle with HREADY=1
- HWDATA  in  WIDTH  AHB write data, valid in the data phase
- fifo_clr  in  1  synchronous flush
- deq  in  1  consumer pops the head word
- rdata  out  WIDTH  head word, valid while rcv_fifo_empty=0
- rcv_fifo_full  out  1  no free slot, counting the reserved pending slot
- rcv_fifo_empty  out  1  no stored word
- count  out  $clog2(DEPTH)+1  stored word count
- fifo_err  out  1  sticky overflow/underflow flag

## Operation
- Storage: mem[DEPTH], wptr/rptr of $clog2(DEPTH) bits, each wrapping DEPTH-1 -> 0, plus count register.
- Capture FSM, two states:
  - IDLE: if rcv_enq_word=1 and HREADY=1 at a clock edge, go to PEND. PEND means the address phase was accepted and the data phase is outstanding.
  - PEND: if HREADY=1, write HWDATA to mem[wptr], advance wptr, and count+1.
    - If rcv_enq_word=1 is also accepted in that same cycle (back-to-back burst beat), stay in PEND; otherwise return to IDLE.
    - If HREADY=0, hold PEND with no write; the data phase is stretched.
- rcv_fifo_full = (count + (state==PEND)) == DEPTH. The reserved slot counts as occupied.
- rcv_fifo_empty = (count == 0). A pending-but-unwritten word does not clear empty.
- Dequeue: deq=1 with count>0 advances rptr and count-1. rdata = mem[rptr], show-ahead and combinational from storage.
- Simultaneous write and deq with count>0: both pointers advance and count is unchanged. With count==0, deq is an underflow and the write still occurs.
- Overflow: a PEND write completing when count==DEPTH drops the word, leaves wptr/count unchanged, and sets fifo_err.
- Underflow: deq with count==0 leaves pointers unchanged and sets fifo_err.
- fifo_err clears only on HRESET or fifo_clr.
- fifo_clr=1 at an edge: wptr=rptr=0, count=0, state=IDLE, fifo_err=0. Any pending data phase is discarded and all other activity that cycle is ignored. Memory contents are not cleared.
- Count arithmetic: unsigned, never wraps, bounded to 0..DEPTH.

## Timing
- Reset values: wptr=rptr=0, count=0, state=IDLE, fifo_err=0. Outputs: rcv_fifo_empty=1, rcv_fifo_full=0, count=0, fifo_err=0. rdata is don't-care; mem is not reset.
- Reset asserted mid-burst: state returns to IDLE immediately, with no write of the in-flight word.
- Write latency: with the address phase accepted in cycle N and HREADY=1 in N+1, the word is written at the end of N+1. rcv_fifo_empty falls and rdata is valid in N+2.
- rcv_fifo_full rises in cycle N+1 when the reservation fills the last slot, one cycle before count reaches DEPTH.
- Deq latency: a pop at the end of cycle M shows the next word on rdata in M+1.
- Full/empty are registered-state functions only. They have no combinational path from deq, rcv_enq_word or HWDATA.
- Sustained throughput: one word per cycle in, and one word per cycle out, concurrently.

## Test plan
- Reset, then an 8-beat burst of rcv_enq_word with HREADY=1 and HWDATA=0x1000_0000+i:
  - rcv_fifo_full=1 after the 8th address phase.
  - count=8 two cycles after the last address.
  - Eight deq cycles return rdata 0x1000_0000..0x1000_0007 in order, then empty=1.
- Address phase accepted, then HREADY=0 for 3 cycles with HWDATA=0xDEAD_BEEF changing to 0xCAFE_F00D in the cycle HREADY rises:
  - Exactly one word is stored, equal to 0xCAFE_F00D.
  - count stays 0 during the stall.
- FIFO at count=4 with concurrent write of 0xA5A5_A5A5 and deq every cycle for 20 cycles:
  - count stays 4.
  - Pointers wrap without error and data order is preserved.
  - fifo_err=0 throughout.
- Force a write when count=8: word dropped, count=8, fifo_err=1. deq on empty also sets fifo_err. fifo_clr returns count=0, empty=1, fifo_err=0.
- Assert HRESET asynchronously while in PEND with count=3: outputs go immediately to empty=1, count=0, full=0. After release, the next single enqueue of 0x0000_0011 appears as the first rdata.
